// File: rtl/vr_stream_sink_checker.sv
// Receiving end of a valid/ready stream: checks each accepted word against a preloaded
// expected-value memory and reports the mismatch count, the first failing index and completion.
module vr_stream_sink_checker #(
  parameter int          T        = 16,
  parameter int          NUMVALS  = 20000,
  parameter int          AW       = $clog2(NUMVALS),
  parameter bit          STALL_EN = 1'b1,
  parameter logic [15:0] SEED     = 16'hACE1,
  // Error counter width (1..16). A narrow counter makes saturation reachable in short runs.
  parameter int          ECW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [T-1:0]  in_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [T-1:0]  wr_data,
  output logic          busy,
  output logic          done,
  output logic [15:0]   err_count,
  output logic          first_err_valid,
  output logic [AW-1:0] first_err_idx
);

  // state | meaning
  // IDLE  | waiting for start; expected memory writable
  // RUN   | consuming words; LFSR throttles in_ready
  // DONE  | all NUMVALS words checked; status held, memory writable
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [AW:0]   NUM_W    = (AW+1)'(NUMVALS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUMVALS - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q;
  logic [ECW-1:0]  err_q;
  logic            fev_q;
  logic [AW-1:0]   fei_q;
  logic [15:0]     lfsr_q;
  logic [15:0]     lfsr_next;
  logic [T-1:0]    mem [NUMVALS];
  logic [T-1:0]    exp_word;
  logic            ready_int;
  logic            xfer;
  logic            mismatch;
  logic            start_run;
  logic            idx_last;
  logic            idx_in_range;
  logic            wr_in_range;

  // Fibonacci LFSR, taps 16,14,13,11 in right-shift form (bits 0,2,3,5 feed bit 15).
  assign lfsr_next    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  assign exp_word     = mem[idx_q];
  assign idx_in_range = ({1'b0, idx_q} < NUM_W);
  assign idx_last     = (idx_q == LAST_IDX);
  assign wr_in_range  = ({1'b0, wr_addr} < NUM_W);
  assign ready_int    = (state_q == RUN) && idx_in_range && (STALL_EN ? lfsr_q[0] : 1'b1);
  assign xfer         = in_valid && ready_int;
  assign mismatch     = (in_data != exp_word);
  assign start_run    = start && (state_q != RUN);

  assign in_ready        = ready_int;
  assign err_count       = 16'(err_q);
  assign first_err_valid = fev_q;
  assign first_err_idx   = fei_q;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (xfer && idx_last) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fei_q   <= '0;
      lfsr_q  <= SEED;
    end else begin
      state_q <= state_d;
      if (state_q == RUN) lfsr_q <= lfsr_next;
      if (start_run) begin
        idx_q <= '0;
        err_q <= '0;
        fev_q <= 1'b0;
        fei_q <= '0;
      end else if (xfer) begin
        // idx parks on the last index so it never wraps on power-of-two NUMVALS
        if (!idx_last) idx_q <= idx_q + 1'b1;
        if (mismatch) begin
          if (err_q != '1) err_q <= err_q + 1'b1;
          if (!fev_q) begin
            fev_q <= 1'b1;
            fei_q <= idx_q;
          end
        end
      end
    end
  end

  // Memory survives reset so a self-test can be rerun without reloading.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q != RUN) && wr_in_range) mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_vr_stream_sink_checker.sv
// Directed bench for vr_stream_sink_checker: three instances cover the
// unthrottled path, LFSR throttling, and error-counter saturation.
module tb_vr_stream_sink_checker;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instance A: NUMVALS=4, no throttling
  logic        a_start = 0, a_valid = 0, a_ready, a_wr_en = 0, a_busy, a_done, a_fev;
  logic [15:0] a_data = 0, a_wr_data = 0, a_err;
  logic [1:0]  a_wr_addr = 0, a_fei;

  vr_stream_sink_checker #(.T(16), .NUMVALS(4), .STALL_EN(1'b0)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .busy(a_busy), .done(a_done), .err_count(a_err), .first_err_valid(a_fev),
    .first_err_idx(a_fei));

  // Instance B: NUMVALS=8, LFSR-throttled
  logic        b_start = 0, b_valid = 0, b_ready, b_wr_en = 0, b_busy, b_done, b_fev;
  logic [15:0] b_data = 0, b_wr_data = 0, b_err;
  logic [2:0]  b_wr_addr = 0, b_fei;

  vr_stream_sink_checker #(.T(16), .NUMVALS(8), .STALL_EN(1'b1), .SEED(16'hACE1)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .busy(b_busy), .done(b_done), .err_count(b_err), .first_err_valid(b_fev),
    .first_err_idx(b_fei));

  // Instance C: NUMVALS=6 with a 2-bit error counter (saturates at 3)
  logic        c_start = 0, c_valid = 0, c_ready, c_wr_en = 0, c_busy, c_done, c_fev;
  logic [15:0] c_data = 0, c_wr_data = 0, c_err;
  logic [2:0]  c_wr_addr = 0, c_fei;

  vr_stream_sink_checker #(.T(16), .NUMVALS(6), .STALL_EN(1'b0), .ECW(2)) dut_c (
    .clk(clk), .reset(reset), .start(c_start), .in_valid(c_valid), .in_ready(c_ready),
    .in_data(c_data), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
    .busy(c_busy), .done(c_done), .err_count(c_err), .first_err_valid(c_fev),
    .first_err_idx(c_fei));

  task automatic a_write(input logic [1:0] addr, input logic [15:0] d);
    a_wr_en = 1; a_wr_addr = addr; a_wr_data = d;
    step();
    a_wr_en = 0;
  endtask

  task automatic a_send(input logic [15:0] d);
    a_valid = 1; a_data = d;
    step();
    a_valid = 0;
  endtask

  task automatic a_go();
    a_start = 1;
    step();
    a_start = 0;
  endtask

  task automatic a_send4(input logic [15:0] d0, d1, d2, d3);
    a_send(d0); a_send(d1); a_send(d2); a_send(d3);
  endtask

  logic [15:0] m_lfsr;
  logic [15:0] vpat;
  logic        exp_rdy;
  int          midx;
  int          cyc;

  initial begin
    // ---- reset ----
    reset = 0;
    step(); step();
    check("rst_ready", a_ready, 0);
    check("rst_busy",  a_busy, 0);
    check("rst_done",  a_done, 0);
    check("rst_err",   a_err, 0);
    check("rst_fev",   a_fev, 0);
    reset = 1;
    step();

    // ---- A: clean run, consecutive transfers ----
    a_write(0, 16'd1); a_write(1, 16'd2); a_write(2, 16'd3); a_write(3, 16'd4);
    a_go();
    check("a1_busy",  a_busy, 1);
    check("a1_ready", a_ready, 1);
    a_send(16'd1); a_send(16'd2); a_send(16'd3);
    check("a1_done_early", a_done, 0);
    check("a1_busy_mid",   a_busy, 1);
    a_send(16'd4);
    check("a1_done",  a_done, 1);
    check("a1_busy0", a_busy, 0);
    check("a1_rdy0",  a_ready, 0);
    check("a1_err",   a_err, 0);
    check("a1_fev",   a_fev, 0);

    // ---- A: two mismatches ----
    a_go();
    check("a2_err_clr", a_err, 0);
    a_send4(16'd1, 16'd9, 16'd3, 16'd7);
    check("a2_err",  a_err, 2);
    check("a2_fev",  a_fev, 1);
    check("a2_fei",  a_fei, 1);
    check("a2_done", a_done, 1);

    // ---- A: single mismatch at the last index ----
    a_go();
    a_send4(16'd1, 16'd2, 16'd3, 16'd5);
    check("a3_err", a_err, 1);
    check("a3_fei", a_fei, 3);

    // ---- A: restart from DONE clears status; writes in RUN ignored; start in RUN ignored ----
    a_go();
    check("a4_busy", a_busy, 1);
    check("a4_err",  a_err, 0);
    check("a4_fev",  a_fev, 0);
    a_write(0, 16'hFFFF);
    a_send(16'd1);
    a_send(16'd9);
    a_go();
    check("a4_start_ign_busy", a_busy, 1);
    check("a4_start_ign_err",  a_err, 1);
    a_send(16'd3);
    a_send(16'd4);
    check("a4_done", a_done, 1);
    check("a4_err2", a_err, 1);
    check("a4_fei",  a_fei, 1);

    // ---- A: simultaneous start and write in DONE ----
    a_start = 1; a_wr_en = 1; a_wr_addr = 3; a_wr_data = 16'd7;
    step();
    a_start = 0; a_wr_en = 0;
    a_send4(16'd1, 16'd2, 16'd3, 16'd7);
    check("a5_err",  a_err, 0);
    check("a5_done", a_done, 1);

    // ---- A: reset mid-run ----
    a_go();
    a_send(16'd1);
    a_send(16'd9);
    check("a6_err_pre", a_err, 1);
    reset = 0;
    step();
    check("a6_busy",  a_busy, 0);
    check("a6_done",  a_done, 0);
    check("a6_ready", a_ready, 0);
    check("a6_err",   a_err, 0);
    check("a6_fev",   a_fev, 0);
    reset = 1;
    a_go();
    a_send4(16'd1, 16'd2, 16'd3, 16'd7);
    check("a6_rerun_err",  a_err, 0);
    check("a6_rerun_done", a_done, 1);

    // ---- B: LFSR-throttled in_ready, toggling valid ----
    for (int i = 0; i < 8; i++) begin
      b_wr_en = 1; b_wr_addr = 3'(i); b_wr_data = 16'(16'h1000 + i * 273);
      step();
    end
    b_wr_en = 0;
    b_start = 1;
    step();
    b_start = 0;
    m_lfsr = 16'hACE1;
    vpat   = 16'b1101_0011_1011_0101;
    midx   = 0;
    cyc    = 0;
    while (midx < 8 && cyc < 200) begin
      b_valid = vpat[cyc % 16];
      b_data  = 16'(16'h1000 + midx * 273);
      exp_rdy = m_lfsr[0];
      check($sformatf("b_ready_c%0d", cyc), b_ready, exp_rdy);
      step();
      if (b_valid && exp_rdy) midx++;
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      cyc++;
    end
    b_valid = 0;
    check("b_budget", midx, 8);
    check("b_done",   b_done, 1);
    check("b_err",    b_err, 0);
    check("b_fev",    b_fev, 0);

    // ---- C: error counter saturation ----
    for (int i = 0; i < 6; i++) begin
      c_wr_en = 1; c_wr_addr = 3'(i); c_wr_data = 16'(i);
      step();
    end
    c_wr_en = 0;
    c_start = 1;
    step();
    c_start = 0;
    for (int i = 0; i < 6; i++) begin
      c_valid = 1; c_data = 16'(i + 100);
      step();
      check($sformatf("c_err_%0d", i), c_err, (i + 1 > 3) ? 3 : i + 1);
    end
    c_valid = 0;
    check("c_fei",  c_fei, 0);
    check("c_fev",  c_fev, 1);
    check("c_done", c_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/vr_stream_sink_checker.md
Name: vr_stream_sink_checker

Overview:
- Synthesizable consumer (receiver) end of the team's valid/ready stream protocol.
- Attaches to the output port of an fc_* layer.
- Accepts NUMVALS words with pseudo-random back-pressure, compares each against a preloaded expected-value memory, and reports error count, first failing index and completion.
- Lets on-chip/FPGA self-test replace the simulation-only output checker.

Parameters:
- T, 16, data word width in bits.
- NUMVALS, 20000, number of words consumed per run.
- AW, $clog2(NUMVALS), address/index width.
- STALL_EN, 1, 1 = LFSR-throttled in_ready; 0 = in_ready held high while running.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- in_valid  in  1  producer has a word.
- in_ready  out  1  checker will accept a word this cycle.
- in_data  in  T  signed word from producer.
- wr_en  in  1  expected-memory write strobe; honoured only in IDLE/DONE.
- wr_addr  in  AW  expected-memory write address.
- wr_data  in  T  expected-memory write data.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- err_count  out  16  mismatches this run; saturates at 16'hFFFF.
- first_err_valid  out  1  at least one mismatch seen this run.
- first_err_idx  out  AW  index of first mismatch; valid only with first_err_valid.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, idx=0, err_count=0, first_err_valid=0, first_err_idx=0, lfsr=SEED.
  - Outputs: in_ready=0, busy=0, done=0.
  - Expected memory is not cleared.
  - Reset mid-RUN aborts the run; no partial status is kept.
- States:
  - IDLE: in_ready=0. start -> RUN; clears idx, err_count, first_err_*.
  - RUN: busy=1. in_ready = (idx<NUMVALS) & (STALL_EN ? lfsr[0] : 1). in_ready is registered-state-derived only; it never depends combinationally on in_valid.
  - DONE: done=1, in_ready=0. Holds status until start (-> RUN, status cleared) or reset.
- Transfer:
  - A transfer occurs at a posedge where in_valid & in_ready.
  - Only a transfer compares in_data to mem[idx] and increments idx.
  - in_valid without in_ready: no state change. Producer must hold data, per protocol.
- Mismatch (in_data != mem[idx]):
  - err_count++ (saturating).
  - If first_err_valid==0: first_err_idx<=idx, first_err_valid<=1.
- Completion:
  - The transfer with idx==NUMVALS-1 moves to DONE on the same edge.
  - done is visible the next cycle; the last comparison is already reflected in err_count.
- Memory:
  - Read is combinational at mem[idx] (zero latency), so every accepted word is checked the same cycle.
  - Write is synchronous.
  - wr_en during RUN is ignored.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Shifts every cycle in RUN only; holds in IDLE/DONE.
  - Reloaded to SEED on reset. start does not reseed, so runs repeat only after reset.
- start while in RUN: ignored.
- Simultaneous start and wr_en in IDLE: both take effect. The write lands before the first possible transfer (the next cycle).
- Arithmetic:
  - Comparison is bitwise on all T bits.
  - idx and first_err_idx are unsigned AW bits; idx never wraps, since RUN exits at NUMVALS.

Test Plan:
- NUMVALS=4, STALL_EN=0; load mem={1,2,3,4}; start; producer sends 1,2,3,4 with in_valid always 1 -> 4 transfers on 4 consecutive edges; done=1 one cycle after the 4th; err_count=0, first_err_valid=0.
- Same setup, producer sends 1,9,3,7 -> err_count=2, first_err_valid=1, first_err_idx=1.
- STALL_EN=1, NUMVALS=8, producer valid randomly toggled -> idx advances only on valid&ready; in_ready matches a reference LFSR model from SEED cycle-by-cycle; all 8 checked, err_count=0.
- Reset pulled low after 2 transfers in RUN -> next cycle busy=0, done=0, in_ready=0, err_count=0; a new start re-checks from idx 0.
- In DONE with err_count=1: start -> busy=1, err_count=0, first_err_valid=0. wr_en during RUN to address 0 with 16'hFFFF -> mem[0] unchanged (verify via a second run).
- Force 16'hFFFF mismatches (NUMVALS=70000, or a reduced-width counter build parameter) -> err_count sticks at 16'hFFFF, no wrap.
